rst_seq_ctrl: RTL and testbench

Reset sequencing controller for the CDC reset infrastructure. It holds a set of downstream domain resets asserted, then releases them one at a time, in fixed order and with a programmed spacing, so dependent blocks leave reset in a defined order. Its outputs are active-low and feed the per-domain reset synchronizers. It also services a software reset request with a level req/ack handshake, which re-asserts all domains and then replays the release sequence.

---
 rtl/rst_seq_ctrl.sv | 108 ++++++++++
 tb/tb_rst_seq_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds NUM_DOMAINS active-low resets low, then releases them
// in order 0..N-1, HOLD_CYCLES apart. Software req/ack re-asserts all and replays.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    output logic                   SW_RST_ACK,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   SEQ_DONE,
    output logic [1:0]             STATE
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_RUN   = 2'b10;
    localparam logic [1:0] ST_SWRST = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
    logic                   seq_done_q, seq_done_d;
    logic                   ack_q, ack_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dom_rst_n_d = dom_rst_n_q;
        seq_done_d  = seq_done_q;
        ack_d       = ack_q;
        case (state_q)
            ST_WAIT: begin
                // Software requests are deliberately not sampled here; the level
                // request is picked up once RUN is reached.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            dom_rst_n_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d    = ST_RUN;
                        seq_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (SW_RST_REQ) begin
                    dom_rst_n_d = '0;
                    seq_done_d  = 1'b0;
                    ack_d       = 1'b1;
                    state_d     = ST_SWRST;
                end
            end
            ST_SWRST: begin
                if (!SW_RST_REQ) begin
                    ack_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                dom_rst_n_d = '0;
                seq_done_d  = 1'b0;
                ack_d       = 1'b0;
                cnt_d       = '0;
                idx_d       = '0;
                state_d     = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            seq_done_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_n_q <= dom_rst_n_d;
            seq_done_q  <= seq_done_d;
            ack_q       <= ack_d;
        end
    end

    assign DOM_RST_N  = dom_rst_n_q;
    assign SEQ_DONE   = seq_done_q;
    assign SW_RST_ACK = ack_q;
    assign STATE      = state_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: 4 domains / hold 8, plus 3 domains / hold 1.
module tb_rst_seq_ctrl;
    logic       CLK;
    logic       rst, req, ack, done;
    logic [3:0] dom;
    logic [1:0] st;
    logic       rst2, req2, ack2, done2;
    logic [2:0] dom2;
    logic [1:0] st2;

    int checks = 0;
    int errors = 0;

    rst_seq_ctrl #(.NUM_DOMAINS(4), .HOLD_CYCLES(8), .CNT_WIDTH(4)) u_dut (
        .CLK(CLK), .RST(rst), .SW_RST_REQ(req), .SW_RST_ACK(ack),
        .DOM_RST_N(dom), .SEQ_DONE(done), .STATE(st)
    );

    rst_seq_ctrl #(.NUM_DOMAINS(3), .HOLD_CYCLES(1), .CNT_WIDTH(2)) u_dut3 (
        .CLK(CLK), .RST(rst2), .SW_RST_REQ(req2), .SW_RST_ACK(ack2),
        .DOM_RST_N(dom2), .SEQ_DONE(done2), .STATE(st2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    // Released bits must form a thermometer from bit 0; done implies all released.
    always @(negedge CLK) begin
        if (!rst) begin
            chk("therm", 32'(({1'b0, dom} + 5'd1) & {1'b0, dom}), 32'd0);
            if (done) chk("done_all", 32'(dom), 32'hF);
        end
        if (!rst2 && done2) chk("done_all3", 32'(dom2), 32'h7);
    end

    initial begin
        rst = 1'b1; req = 1'b0;
        rst2 = 1'b1; req2 = 1'b0;

        // Power-on sequence
        step(3);
        chk("rst_dom", 32'(dom), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_state", 32'(st), 32'h1);
        rst = 1'b0;
        step(7);
        chk("e7_dom", 32'(dom), 32'h0);
        step(1);
        chk("e8_dom", 32'(dom), 32'h1);
        step(8);
        chk("e16_dom", 32'(dom), 32'h3);
        step(8);
        chk("e24_dom", 32'(dom), 32'h7);
        chk("e24_done", 32'(done), 32'h0);
        step(8);
        chk("e32_dom", 32'(dom), 32'hF);
        chk("e32_done", 32'(done), 32'h1);
        chk("e32_state", 32'(st), 32'h2);

        // Software reset: request held for 5 sampled edges
        step(2);
        chk("run_hold", 32'(dom), 32'hF);
        req = 1'b1;
        step(1);
        chk("sw_dom", 32'(dom), 32'h0);
        chk("sw_ack", 32'(ack), 32'h1);
        chk("sw_done", 32'(done), 32'h0);
        chk("sw_state", 32'(st), 32'h3);
        step(4);
        chk("sw_ack_hold", 32'(ack), 32'h1);
        req = 1'b0;
        step(1);
        chk("swx_ack", 32'(ack), 32'h0);
        chk("swx_state", 32'(st), 32'h1);
        step(7);
        chk("swx_e7_dom", 32'(dom), 32'h0);
        step(1);
        chk("swx_e8_dom", 32'(dom), 32'h1);
        step(24);
        chk("swx_e32_dom", 32'(dom), 32'hF);
        chk("swx_e32_done", 32'(done), 32'h1);

        // Mid-sequence asynchronous reset
        restart();
        step(20);
        chk("mid_e20_dom", 32'(dom), 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("mid_async_dom", 32'(dom), 32'h0);
        chk("mid_async_state", 32'(st), 32'h1);
        step(1);
        rst = 1'b0;
        step(7);
        chk("mid_e7_dom", 32'(dom), 32'h0);
        step(1);
        chk("mid_e8_dom", 32'(dom), 32'h1);

        // Early request, held from edge 5 of a fresh sequence
        restart();
        step(5);
        req = 1'b1;
        step(15);
        chk("early_e20_ack", 32'(ack), 32'h0);
        chk("early_e20_dom", 32'(dom), 32'h3);
        step(11);
        chk("early_e31_ack", 32'(ack), 32'h0);
        chk("early_e31_state", 32'(st), 32'h1);
        step(1);
        chk("early_e32_done", 32'(done), 32'h1);
        chk("early_e32_dom", 32'(dom), 32'hF);
        chk("early_e32_ack", 32'(ack), 32'h0);
        step(1);
        chk("early_e33_dom", 32'(dom), 32'h0);
        chk("early_e33_ack", 32'(ack), 32'h1);
        chk("early_e33_state", 32'(st), 32'h3);
        req = 1'b0;
        step(1);
        chk("early_drop_ack", 32'(ack), 32'h0);

        // HOLD_CYCLES=1, NUM_DOMAINS=3
        chk("h1_rst_dom", 32'(dom2), 32'h0);
        rst2 = 1'b0;
        step(1);
        chk("h1_e1_dom", 32'(dom2), 32'h1);
        chk("h1_e1_done", 32'(done2), 32'h0);
        step(1);
        chk("h1_e2_dom", 32'(dom2), 32'h3);
        step(1);
        chk("h1_e3_dom", 32'(dom2), 32'h7);
        chk("h1_e3_done", 32'(done2), 32'h1);
        chk("h1_e3_state", 32'(st2), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
